sliding_detector_window_buffer: RTL and testbench
=================================================

Name: sliding_detector_window_buffer

Overview:
- Upstream feeder for the sliding-window error detector.
- Each cycle it accepts one frame of `width` residual-error samples and `width` sliced bits from the error-estimation stage.
- It saturates the errors to the detector's error width and keeps a history of the last `sliding_detector_depth` frames.
- It presents that history as one flattened, time-ordered window with a valid strobe, so the detector can evaluate every position of a frame, including sequences that run into the next frame.

Parameters:
- width, 16, samples per frame (parallel lanes)
- sliding_detector_depth, 2, frames held in the output window (>=2)
- in_error_bitwidth, 10, signed width of incoming residual errors
- est_error_bitwidth, 8, signed width of window errors (<= in_error_bitwidth)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rstb  input  1  synchronous active-low reset
- in_valid  input  1  frame on in_error/in_bits is valid this cycle
- flush  input  1  discard history; window refills from scratch
- in_error  input  signed [in_error_bitwidth-1:0] x [width-1:0]  residual error per lane; lane 0 is earliest in time
- in_bits  input  [width-1:0] x 1  sliced bit per lane
- errstream  output  signed [est_error_bitwidth-1:0] x [width*sliding_detector_depth-1:0]  window errors; index 0 is oldest
- bitstream  output  1 x [width*sliding_detector_depth-1:0]  window bits, same ordering
- out_valid  output  1  window is complete and updated this cycle
- fill_count  output  [$clog2(sliding_detector_depth+1)-1:0]  frames currently held, saturates at sliding_detector_depth
- sat_flag  output  1  at least one sample of the most recently accepted frame was clipped

Behaviour:
- Reset, when rstb=0 at a clk edge: all history registers 0, errstream all 0, bitstream all 0, out_valid=0, fill_count=0, sat_flag=0. A reset mid-fill discards partial history.
- Saturation, per lane:
  - x > 2^(E-1)-1 -> 2^(E-1)-1
  - x < -2^(E-1) -> -2^(E-1)
  - otherwise sign-preserving truncation to E bits, where E = est_error_bitwidth.
  - No rounding, and the clip is symmetric only at the positive edge (two's complement).
- Accept, on in_valid=1 and flush=0:
  - Shift history by one frame; the oldest frame is dropped.
  - The new frame occupies window indices (D-1)*width .. D*width-1, with lane i at index (D-1)*width+i.
  - Frame f (0 = oldest) occupies indices f*width .. f*width+width-1, with lane order preserved.
  - fill_count = min(fill_count+1, D).
- Hold, on in_valid=0 and flush=0: history, fill_count and sat_flag unchanged; out_valid=0.
- out_valid is registered and asserts for exactly one cycle on the edge that accepts a frame when the post-update fill_count == D.
  - Latency: a frame presented at edge N appears in errstream/bitstream, and out_valid asserts, after edge N (visible in cycle N+1).
  - The first out_valid follows the D-th accepted frame after reset or flush.
  - With in_valid held high, out_valid stays high every cycle thereafter.
- errstream and bitstream change only on accepting edges. They are stable while out_valid=0, and are don't-care to the consumer while fill_count < D.
- sat_flag is updated on each accepting edge to the OR of the per-lane clip indicators of that frame, and holds otherwise.
- Flush, when flush=1 with rstb=1:
  - fill_count is cleared to 0 and out_valid=0; history contents are not cleared.
  - If in_valid=1 in the same cycle, the incoming frame is accepted as the first frame: it shifts in and fill_count=1. Flush takes priority over the old history, not over the new frame.
- No backpressure: the consumer is combinational and must take every out_valid window.
- Signals sampled while rstb=0 are ignored.

Test Plan:
- Reset then fill, D=2, width=16: frame A (lane i error=i, bits=1) then frame B (error=-i, bits=0).
  - Required: out_valid=0 after A and fill_count=1.
  - After B: out_valid=1, errstream[0..15]=0..15, errstream[16..31]=0..-15, bitstream[0..15]=1, bitstream[16..31]=0.
- Continuous stream of frames C, D, E, one per cycle:
  - out_valid high every cycle after the second frame.
  - Window after E = {D at indices 0..15, E at indices 16..31}.
- Saturation, in_error_bitwidth=10, E=8: inputs 300, -300, 127, -128, -129 on lanes 0-4.
  - Required window values: 127, -128, 127, -128, -128; sat_flag=1.
  - Next frame with all values in range -> sat_flag=0.
- Gaps: apply in_valid=0 for 5 cycles between frames.
  - Required: out_valid=0 during the gap; errstream, bitstream and fill_count unchanged; the next accepted frame produces a one-cycle out_valid.
- Flush with a simultaneous frame while full: flush=1, in_valid=1 with frame F.
  - Required: fill_count=1, out_valid=0.
  - The next frame G gives out_valid=1 with window {F, G}.
- Reset mid-operation: rstb=0 for one cycle while full and streaming.
  - Required: all outputs 0 next cycle.
  - Two further frames are needed before out_valid reasserts.

Source files
------------

// File: rtl/sliding_detector_window_buffer.sv
// Purpose: saturates per-lane residual errors and keeps the last D frames as one time-ordered window.
// Latency: a frame accepted at edge N is in errstream/bitstream, with out_valid, from cycle N+1.
// Backpressure: none; every accepted frame shifts in and every out_valid window must be consumed.
module sliding_detector_window_buffer #(
    parameter int width                  = 16,
    parameter int sliding_detector_depth = 2,
    parameter int in_error_bitwidth      = 10,
    parameter int est_error_bitwidth     = 8
) (
    input  logic                                 clk,
    input  logic                                 rstb,
    input  logic                                 in_valid,
    input  logic                                 flush,
    input  logic signed [in_error_bitwidth-1:0]  in_error [width],
    input  logic [width-1:0]                     in_bits,
    output logic signed [est_error_bitwidth-1:0] errstream [width*sliding_detector_depth],
    output logic [width*sliding_detector_depth-1:0] bitstream,
    output logic                                 out_valid,
    output logic [$clog2(sliding_detector_depth+1)-1:0] fill_count,
    output logic                                 sat_flag
);

    localparam int W  = width;
    localparam int D  = sliding_detector_depth;
    localparam int N  = W * D;
    localparam int E  = est_error_bitwidth;
    localparam int IW = in_error_bitwidth;
    localparam int FW = $clog2(D + 1);

    localparam logic signed [E-1:0]  EST_MAX = {1'b0, {(E-1){1'b1}}};
    localparam logic signed [E-1:0]  EST_MIN = {1'b1, {(E-1){1'b0}}};
    localparam logic signed [IW-1:0] IN_MAX  = IW'(EST_MAX);
    localparam logic signed [IW-1:0] IN_MIN  = IW'(EST_MIN);
    localparam logic [FW-1:0]        FULL    = FW'(D);
    localparam logic [FW-1:0]        ONE     = FW'(1);

    logic signed [E-1:0] sat_err [W];
    logic [W-1:0]        clip;
    logic [FW-1:0]       fill_next;

    always_comb begin
        for (int i = 0; i < W; i++) begin
            sat_err[i] = in_error[i][E-1:0];
            clip[i]    = 1'b0;
            if (in_error[i] > IN_MAX) begin
                sat_err[i] = EST_MAX;
                clip[i]    = 1'b1;
            end else if (in_error[i] < IN_MIN) begin
                sat_err[i] = EST_MIN;
                clip[i]    = 1'b1;
            end
        end
    end

    // Flush drops the count but still admits a same-cycle frame as the first one.
    always_comb begin
        fill_next = fill_count;
        if (flush) begin
            fill_next = in_valid ? ONE : '0;
        end else if (in_valid && (fill_count != FULL)) begin
            fill_next = fill_count + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int k = 0; k < N; k++) begin
                errstream[k] <= '0;
            end
            bitstream  <= '0;
            out_valid  <= 1'b0;
            fill_count <= '0;
            sat_flag   <= 1'b0;
        end else begin
            fill_count <= fill_next;
            out_valid  <= in_valid && (fill_next == FULL);
            if (in_valid) begin
                for (int k = 0; k < N - W; k++) begin
                    errstream[k] <= errstream[k+W];
                end
                for (int i = 0; i < W; i++) begin
                    errstream[N-W+i] <= sat_err[i];
                end
                bitstream <= {in_bits, bitstream[N-1:W]};
                sat_flag  <= |clip;
            end
        end
    end

endmodule

// File: tb/tb_sliding_detector_window_buffer.sv
// Directed bench for sliding_detector_window_buffer: table of per-cycle vectors with hand-computed
// expectations, plus a hand-written flush-and-stream sequence.
module tb_sliding_detector_window_buffer;

    localparam int W  = 16;
    localparam int D  = 2;
    localparam int IW = 10;
    localparam int E  = 8;
    localparam int NO = -1;   // window not checked
    localparam int Z  = 15;   // all-zero frame

    logic                 clk = 1'b0;
    logic                 rstb;
    logic                 in_valid;
    logic                 flush;
    logic signed [IW-1:0] in_error [W];
    logic [W-1:0]         in_bits;
    logic signed [E-1:0]  errstream [W*D];
    logic [W*D-1:0]       bitstream;
    logic                 out_valid;
    logic [1:0]           fill_count;
    logic                 sat_flag;

    int n_checks = 0;
    int n_pass   = 0;

    sliding_detector_window_buffer #(
        .width(W), .sliding_detector_depth(D),
        .in_error_bitwidth(IW), .est_error_bitwidth(E)
    ) dut (
        .clk(clk), .rstb(rstb), .in_valid(in_valid), .flush(flush),
        .in_error(in_error), .in_bits(in_bits),
        .errstream(errstream), .bitstream(bitstream),
        .out_valid(out_valid), .fill_count(fill_count), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Expected window value per frame and lane, worked out by hand.
    function automatic int exp_err(input int id, input int lane);
        case (id)
            0: return lane;
            1: return -lane;
            2: return lane * 8;
            3: return -(lane * 8) - 1;
            4: return lane + 40;
            5: return 100 - lane;
            6: return lane - 50;
            7: case (lane)
                   0: return 127;
                   1: return -128;
                   2: return 127;
                   3: return -128;
                   4: return -128;
                   default: return 0;
               endcase
            8: return lane - 8;
            default: return 0;
        endcase
    endfunction

    function automatic int raw_err(input int id, input int lane);
        if (id == 7) begin
            case (lane)
                0: return 300;
                1: return -300;
                2: return 127;
                3: return -128;
                4: return -129;
                default: return 0;
            endcase
        end
        return exp_err(id, lane);
    endfunction

    function automatic logic [W-1:0] frame_bits(input int id);
        case (id)
            0: return 16'hFFFF;
            1: return 16'h0000;
            2: return 16'hAAAA;
            3: return 16'h5555;
            4: return 16'h00FF;
            5: return 16'hA5A5;
            6: return 16'h0FF0;
            8: return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    typedef struct {
        logic rstb;
        logic vld;
        logic flush;
        int   fid;
        logic ov;
        int   fill;
        logic sat;
        int   wo;
        int   wn;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic f, input int fid,
                       input logic ov, input int fill, input logic sat, input int wo, input int wn);
        vecs.push_back('{r, v, f, fid, ov, fill, sat, wo, wn});
    endtask

    task automatic drive(input logic r, input logic v, input logic f, input int fid);
        @(negedge clk);
        rstb     = r;
        in_valid = v;
        flush    = f;
        for (int i = 0; i < W; i++) in_error[i] = IW'(raw_err(fid, i));
        in_bits = frame_bits(fid);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_window(input string name, input int wo, input int wn);
        int bad;
        int a;
        int x;
        logic [W*D-1:0] eb;
        bad = -1;
        for (int k = 0; k < W * D; k++) begin
            a = errstream[k];
            x = (k < W) ? exp_err(wo, k) : exp_err(wn, k - W);
            if (a != x && bad < 0) bad = k;
        end
        n_checks++;
        if (bad < 0) n_pass++;
        else begin
            a = errstream[bad];
            x = (bad < W) ? exp_err(wo, bad) : exp_err(wn, bad - W);
            $display("FAIL %s errstream[%0d]: got %0d, expected %0d", name, bad, a, x);
        end
        eb = {frame_bits(wn), frame_bits(wo)};
        n_checks++;
        if (bitstream == eb) n_pass++;
        else $display("FAIL %s bitstream: got %h, expected %h", name, bitstream, eb);
    endtask

    initial begin
        rstb = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < W; i++) in_error[i] = '0;
        in_bits = '0;

        //   rstb vld flush fid  ov fill sat  wo  wn
        add(0, 0, 0, 0,  0, 0, 0, Z,  Z);   // reset
        add(1, 1, 0, 0,  0, 1, 0, NO, NO);  // A
        add(1, 1, 0, 1,  1, 2, 0, 0,  1);   // B -> window {A,B}
        add(1, 1, 0, 2,  1, 2, 0, 1,  2);   // C
        add(1, 1, 0, 3,  1, 2, 0, 2,  3);   // D
        add(1, 1, 0, 4,  1, 2, 0, 3,  4);   // E
        add(1, 1, 0, 7,  1, 2, 1, 4,  7);   // saturating frame
        add(1, 1, 0, 8,  1, 2, 0, 7,  8);   // in-range frame clears sat_flag
        for (int g = 0; g < 5; g++) add(1, 0, 0, 2, 0, 2, 0, 7, 8);  // gap, garbage on inputs
        add(1, 1, 0, 2,  1, 2, 0, 8,  2);
        add(1, 0, 0, 0,  0, 2, 0, 8,  2);
        add(1, 1, 1, 5,  0, 1, 0, NO, NO);  // flush + F
        add(1, 1, 0, 6,  1, 2, 0, 5,  6);   // G -> {F,G}
        add(1, 0, 1, 0,  0, 0, 0, 5,  6);   // flush alone keeps window
        add(1, 1, 0, 0,  0, 1, 0, NO, NO);
        add(1, 1, 0, 1,  1, 2, 0, 0,  1);
        add(1, 1, 0, 7,  1, 2, 1, 1,  7);
        add(0, 1, 0, 2,  0, 0, 0, Z,  Z);   // reset mid-stream, frame ignored
        add(1, 1, 0, 3,  0, 1, 0, NO, NO);
        add(1, 1, 0, 4,  1, 2, 0, 3,  4);
        add(1, 1, 1, 7,  0, 1, 1, NO, NO);  // flush + saturating frame
        add(1, 0, 0, 0,  0, 1, 1, NO, NO);  // sat_flag holds
        add(1, 1, 0, 8,  1, 2, 0, 7,  8);

        for (int v = 0; v < vecs.size(); v++) begin
            drive(vecs[v].rstb, vecs[v].vld, vecs[v].flush, vecs[v].fid);
            chk($sformatf("v%0d out_valid", v), int'(out_valid), int'(vecs[v].ov));
            chk($sformatf("v%0d fill_count", v), int'(fill_count), vecs[v].fill);
            chk($sformatf("v%0d sat_flag", v), int'(sat_flag), int'(vecs[v].sat));
            if (vecs[v].wo != NO) chk_window($sformatf("v%0d window", v), vecs[v].wo, vecs[v].wn);
        end

        // Flush, then a back-to-back stream of five frames.
        drive(1, 0, 1, 0);
        chk("stream flush fill_count", int'(fill_count), 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, k);
            chk($sformatf("stream%0d out_valid", k), int'(out_valid), (k >= 1) ? 1 : 0);
            chk($sformatf("stream%0d fill_count", k), int'(fill_count), (k >= 1) ? 2 : 1);
        end
        chk_window("stream final", 3, 4);
        drive(1, 0, 0, 0);
        chk("stream end out_valid", int'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
